// File: rtl/lvl_trg_if.sv
// lvl_trg_if: bundles the control events, sample stream, configuration and
// status of the level-crossing trigger.
//   ctl_rst/ctl_str/ctl_stp : event pulses (reset > start > stop)
//   sti_vld/sti_dat         : signed sample stream
//   cfg_edg/cfg_lvl/cfg_hys : edge select, signed level, unsigned hysteresis
//   cfg_hld                 : holdoff length in clock cycles
//   trg/sts_run/sts_arm     : trigger pulse and run/armed status
// master drives stimulus and configuration; slave is the trigger block.
interface lvl_trg_if #(
    parameter int unsigned DW = 14,
    parameter int unsigned CW = 32
);
    logic                 ctl_rst;
    logic                 ctl_str;
    logic                 ctl_stp;
    logic                 sti_vld;
    logic signed [DW-1:0] sti_dat;
    logic                 cfg_edg;
    logic signed [DW-1:0] cfg_lvl;
    logic        [DW-1:0] cfg_hys;
    logic        [CW-1:0] cfg_hld;
    logic                 trg;
    logic                 sts_run;
    logic                 sts_arm;

    modport master (
        output ctl_rst, ctl_str, ctl_stp, sti_vld, sti_dat,
        output cfg_edg, cfg_lvl, cfg_hys, cfg_hld,
        input  trg, sts_run, sts_arm
    );

    modport slave (
        input  ctl_rst, ctl_str, ctl_stp, sti_vld, sti_dat,
        input  cfg_edg, cfg_lvl, cfg_hys, cfg_hld,
        output trg, sts_run, sts_arm
    );
endinterface

// File: rtl/lvl_trg.sv
// lvl_trg: level-crossing trigger source with hysteresis and holdoff.
// Emits a one-cycle trg pulse when the signed sample stream crosses cfg_lvl
// on the selected edge, after first leaving the hysteresis band on the
// arming side. After each trigger a holdoff of cfg_hld+1 cycles follows.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : lvl_trg_if slave (control events, samples, config, status)
// All outputs are registered.
module lvl_trg #(
    parameter int unsigned DW = 14,
    parameter int unsigned CW = 32
) (
    input  logic      clk,
    input  logic      rst,
    lvl_trg_if.slave  bus
);

    // Two guard bits so lvl +/- hys never wraps for any input values.
    localparam int unsigned TW = DW + 2;

    typedef enum logic [1:0] {
        StIdle,
        StWaitArm,
        StArmed,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            trg_q, trg_d;
    logic            run_q, run_d;
    logic            arm_q, arm_d;

    logic signed [TW-1:0] dat_x;
    logic signed [TW-1:0] lvl_x;
    logic signed [TW-1:0] hys_x;
    logic signed [TW-1:0] thr_x;
    logic                 arm_hit;
    logic                 crs_hit;

    assign dat_x = {{2{bus.sti_dat[DW-1]}}, bus.sti_dat};
    assign lvl_x = {{2{bus.cfg_lvl[DW-1]}}, bus.cfg_lvl};
    assign hys_x = {2'b00, bus.cfg_hys};
    assign thr_x = bus.cfg_edg ? (lvl_x + hys_x) : (lvl_x - hys_x);

    // Band exit on the arming side (strict) and level crossing (inclusive).
    assign arm_hit = bus.sti_vld && (bus.cfg_edg ? (dat_x > thr_x) : (dat_x < thr_x));
    assign crs_hit = bus.sti_vld && (bus.cfg_edg ? (dat_x <= lvl_x) : (dat_x >= lvl_x));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trg_d   = 1'b0;

        // Any control pulse discards a crossing in the same cycle.
        if (bus.ctl_rst) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (bus.ctl_str) begin
            state_d = StWaitArm;
            cnt_d   = '0;
        end else if (bus.ctl_stp) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StWaitArm: begin
                    if (arm_hit) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (crs_hit) begin
                        state_d = StHold;
                        cnt_d   = bus.cfg_hld;
                        trg_d   = 1'b1;
                    end
                end
                StHold: begin
                    // Counter saturates at zero; zero means last holdoff cycle.
                    if (cnt_q == '0) begin
                        state_d = StWaitArm;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        run_d = (state_d != StIdle);
        arm_d = (state_d == StArmed);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            trg_q   <= 1'b0;
            run_q   <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trg_q   <= trg_d;
            run_q   <= run_d;
            arm_q   <= arm_d;
        end
    end

    assign bus.trg     = trg_q;
    assign bus.sts_run = run_q;
    assign bus.sts_arm = arm_q;

endmodule
